// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, S-box tables, state byte indexing and ShiftRows helper.
package aes_pkg;
  localparam int STATE_W = 128;
  typedef enum logic {IDLE = 1'b0, SUB = 1'b1} state_e;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  // State s[r][c] lives in byte 4c+r, byte k at bits [127-8k -: 8].
  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction
  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s, input logic inv);
    logic [STATE_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[STATE_W-1-8*byte_idx(r, c) -: 8] =
          s[STATE_W-1-8*byte_idx(r, inv ? (c - r + 4) % 4 : (c + r) % 4) -: 8];
    return o;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational byte substitution; inverse select exists only with SUB_SHIFT_INV_EN.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
`ifdef SUB_SHIFT_INV_EN
  input  logic       i_inv,
`endif
  output logic [7:0] o_byte
);
`ifdef SUB_SHIFT_INV_EN
  assign o_byte = i_inv ? INV_SBOX[i_byte] : SBOX[i_byte];
`else
  assign o_byte = SBOX[i_byte];
`endif
endmodule

// File: rtl/sub_shift_rows.sv
// sub_shift_rows: iterative SubBytes+ShiftRows, LANES bytes per cycle, registered result and done pulse.
// Defining SUB_SHIFT_INV_EN adds the inv port (InvSubBytes + InvShiftRows).
module sub_shift_rows
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               g_rst_n,
  input  logic [STATE_W-1:0] data_in,
  input  logic               enable,
`ifdef SUB_SHIFT_INV_EN
  input  logic               inv,
`endif
  output logic [STATE_W-1:0] data_out,
  output logic               done,
  output logic               busy
);
  localparam int NB = 16 / LANES;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  state_e             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [STATE_W-1:0] r_buf, w_buf_nxt, r_data_out;
  logic               r_done, w_last, w_inv, w_accept;
  logic [7:0]         w_sb_in [LANES];
  logic [7:0]         w_sb_out [LANES];
`ifdef SUB_SHIFT_INV_EN
  logic               r_inv;
  always_ff @(posedge clk or negedge g_rst_n)
    if (!g_rst_n) r_inv <= 1'b0;
    else if (w_accept) r_inv <= inv;
  assign w_inv = r_inv;
`else
  assign w_inv = 1'b0;
`endif
  assign w_accept = (r_state == IDLE) && enable;
  assign w_last   = r_cnt == CW'(NB - 1);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_sb_in[i] = r_buf[STATE_W-1-8*(LANES*int'(r_cnt)+i) -: 8];
    aes_sbox u_sbox (
      .i_byte(w_sb_in[i]),
`ifdef SUB_SHIFT_INV_EN
      .i_inv (w_inv),
`endif
      .o_byte(w_sb_out[i])
    );
  end
  always_comb begin
    w_buf_nxt = r_buf;
    for (int i = 0; i < LANES; i++)
      w_buf_nxt[STATE_W-1-8*(LANES*int'(r_cnt)+i) -: 8] = w_sb_out[i];
  end
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = SUB;
    else if (r_state == SUB && w_last) w_state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge g_rst_n)
    if (!g_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_buf <= data_in;
        r_cnt <= '0;
      end else if (r_state == SUB) begin
        r_buf <= w_buf_nxt;
        r_cnt <= w_last ? r_cnt : r_cnt + 1'b1;
        if (w_last) begin
          r_data_out <= shift_rows(w_buf_nxt, w_inv);
          r_done     <= 1'b1;
        end
      end
    end
  assign data_out = r_data_out;
  assign done     = r_done;
  assign busy     = r_state == SUB;
endmodule
